// File: rtl/m_bus_bridge_if.sv
// M-stage bus bundle: pipeline-side access signals, data-memory port,
// timer req/ack port, interrupt-generator strobe and status back to the pipe.
`timescale 1ns/1ps
interface m_bus_bridge_if;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_byte_en;
  logic        m_load;
  logic        Req;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_byte_en;
  logic [31:0] dm_rdata;
  logic        tc_sel;
  logic        tc_req;
  logic        tc_we;
  logic [1:0]  tc_addr;
  logic [31:0] tc_wdata;
  logic        tc_ack;
  logic [31:0] tc_rdata;
  logic        ig_we;
  logic [31:0] m_rdata;
  logic        stall;
  logic        bus_err;

  // Bridge side
  modport slave (
    input  m_addr, m_wdata, m_byte_en, m_load, Req, dm_rdata, tc_ack, tc_rdata,
    output dm_addr, dm_wdata, dm_byte_en, tc_sel, tc_req, tc_we, tc_addr,
           tc_wdata, ig_we, m_rdata, stall, bus_err
  );

  // Pipeline/device side
  modport master (
    output m_addr, m_wdata, m_byte_en, m_load, Req, dm_rdata, tc_ack, tc_rdata,
    input  dm_addr, dm_wdata, dm_byte_en, tc_sel, tc_req, tc_we, tc_addr,
           tc_wdata, ig_we, m_rdata, stall, bus_err
  );
endinterface

// File: rtl/m_bus_bridge.sv
// Memory-stage bus controller: decodes the M-stage address, serves DM and IG
// in the access cycle, and runs a stalled req/ack handshake with bounded wait
// for the two timers.
`timescale 1ns/1ps
module m_bus_bridge #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic          clk,
  input logic          reset,
  m_bus_bridge_if.slave bus
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, TWAIT, TDONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [31:0] rbuf, rbuf_nxt;
  logic        to_err, to_err_nxt;
  logic        start;

  logic        sel_q, we_q;
  logic [1:0]  addr_q;
  logic [31:0] wdata_q;

  logic        hit_dm, hit_tc0, hit_tc1, hit_tc, hit_ig;
  logic        is_store, is_access, partial;

  logic [3:0]  dm_be_c;
  logic        ig_we_c, tc_req_c, stall_c, bus_err_c;
  logic [31:0] m_rdata_c;

  // Address decode and access classification
  always_comb begin
    hit_dm    = (bus.m_addr <= 32'h0000_2FFF);
    hit_tc0   = (bus.m_addr >= 32'h0000_7F00) && (bus.m_addr <= 32'h0000_7F0B);
    hit_tc1   = (bus.m_addr >= 32'h0000_7F10) && (bus.m_addr <= 32'h0000_7F1B);
    hit_ig    = (bus.m_addr >= 32'h0000_7F20) && (bus.m_addr <= 32'h0000_7F23);
    hit_tc    = hit_tc0 | hit_tc1;
    is_store  = |bus.m_byte_en;
    is_access = is_store | bus.m_load;
    partial   = is_store && (bus.m_byte_en != 4'b1111);
  end

  // State register, wait counter, read buffer and latched timer request
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rbuf    <= '0;
      to_err  <= 1'b0;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rbuf   <= rbuf_nxt;
      to_err <= to_err_nxt;
      if (start) begin
        sel_q   <= hit_tc1;
        we_q    <= is_store;
        addr_q  <= bus.m_addr[3:2];
        wdata_q <= bus.m_wdata;
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rbuf_nxt   = rbuf;
    to_err_nxt = to_err;
    start      = 1'b0;
    dm_be_c    = '0;
    ig_we_c    = 1'b0;
    tc_req_c   = 1'b0;
    stall_c    = 1'b0;
    bus_err_c  = 1'b0;
    m_rdata_c  = '0;
    case (state)
      IDLE: begin
        if (hit_dm) m_rdata_c = bus.dm_rdata;
        if (is_access && !bus.Req) begin
          if (hit_dm) begin
            dm_be_c = bus.m_byte_en;
          end else if (hit_ig) begin
            if (partial)       bus_err_c = 1'b1;
            else if (is_store) ig_we_c   = 1'b1;
          end else if (hit_tc) begin
            if (partial) begin
              bus_err_c = 1'b1;
            end else begin
              start      = 1'b1;
              stall_c    = 1'b1;
              cnt_nxt    = '0;
              to_err_nxt = 1'b0;
              state_nxt  = TWAIT;
            end
          end else begin
            bus_err_c = 1'b1;
          end
        end
      end
      TWAIT: begin
        tc_req_c = 1'b1;
        stall_c  = 1'b1;
        cnt_nxt  = cnt + 8'd1;
        // Ack wins over a timeout landing in the same cycle
        if (bus.tc_ack) begin
          rbuf_nxt   = we_q ? '0 : bus.tc_rdata;
          to_err_nxt = 1'b0;
          state_nxt  = TDONE;
        end else if (cnt == CNT_LAST) begin
          rbuf_nxt   = '0;
          to_err_nxt = 1'b1;
          state_nxt  = TDONE;
        end
      end
      TDONE: begin
        m_rdata_c = rbuf;
        bus_err_c = to_err;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.dm_addr    = bus.m_addr;
  assign bus.dm_wdata   = bus.m_wdata;
  assign bus.dm_byte_en = dm_be_c;
  assign bus.ig_we      = ig_we_c;
  assign bus.tc_req     = tc_req_c;
  assign bus.tc_sel     = sel_q;
  assign bus.tc_we      = we_q;
  assign bus.tc_addr    = addr_q;
  assign bus.tc_wdata   = wdata_q;
  assign bus.m_rdata    = m_rdata_c;
  assign bus.stall      = stall_c;
  assign bus.bus_err    = bus_err_c;

endmodule

// File: tb/tb_m_bus_bridge.sv
// Bench for m_bus_bridge: directed scenarios plus randomized accesses checked
// against a region/rule reference model and a transaction-level timer model.
`timescale 1ns/1ps
module tb_m_bus_bridge;

  localparam int unsigned TO = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  m_bus_bridge_if bus();

  m_bus_bridge #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic        stall;
    logic        err;
    logic        ig;
    logic [3:0]  be;
    logic [31:0] rd;
  } idle_exp_t;

  // 0 = DM, 1 = TC0, 2 = TC1, 3 = IG, 4 = unmapped
  function automatic int region_of(input logic [31:0] a);
    if (a < 32'h3000) return 0;
    if (a >= 32'h7F00 && a < 32'h7F0C) return 1;
    if (a >= 32'h7F10 && a < 32'h7F1C) return 2;
    if (a >= 32'h7F20 && a < 32'h7F24) return 3;
    return 4;
  endfunction

  // Expected outputs for a cycle in IDLE
  function automatic idle_exp_t model_idle(input logic [31:0] a, input logic [3:0] be,
                                           input logic ld, input logic rq, input logic [31:0] rd);
    idle_exp_t e;
    int r;
    e = '0;
    r = region_of(a);
    if (r == 0) e.rd = rd;
    if (!rq && (ld || be != 4'h0)) begin
      case (r)
        0: e.be = be;
        1, 2: if (be != 4'h0 && be != 4'hF) e.err = 1'b1; else e.stall = 1'b1;
        3: if (be == 4'hF) e.ig = 1'b1; else if (be != 4'h0) e.err = 1'b1;
        default: e.err = 1'b1;
      endcase
    end
    return e;
  endfunction

  function automatic idle_exp_t observed();
    return {bus.tc_req, bus.stall, bus.bus_err, bus.ig_we, bus.dm_byte_en, bus.m_rdata};
  endfunction

  task automatic idle_in();
    bus.m_addr    = 32'h0000_0000;
    bus.m_wdata   = $urandom;
    bus.m_byte_en = 4'h0;
    bus.m_load    = 1'b0;
    bus.Req       = 1'b0;
    bus.tc_ack    = 1'b0;
    bus.tc_rdata  = $urandom;
    bus.dm_rdata  = $urandom;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                       input logic ld, input logic rq);
    bus.m_addr    = a;
    bus.m_wdata   = wd;
    bus.m_byte_en = be;
    bus.m_load    = ld;
    bus.Req       = rq;
    bus.tc_ack    = 1'b0;
    bus.dm_rdata  = $urandom;
  endtask

  // Single non-timer IDLE cycle checked against the model
  task automatic idle_access(input string nm, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be, input logic ld, input logic rq);
    idle_exp_t e;
    @(posedge clk) #1;
    drive(a, wd, be, ld, rq);
    e = model_idle(a, be, ld, rq, bus.dm_rdata);
    @(negedge clk);
    checks++;
    if (observed() !== e || bus.dm_addr !== a || bus.dm_wdata !== wd) begin
      failures++;
      $display("FAIL %s addr=%h: got {req,stall,err,ig,be,rd}=%h dm_addr=%h dm_wdata=%h, want %h %h %h",
               nm, a, observed(), bus.dm_addr, bus.dm_wdata, e, a, wd);
    end
  endtask

  // Timer access: ack driven in wait cycle k (k > TO means the ack never arrives in time)
  task automatic timer_access(input string nm, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] be, input logic ld, input int k);
    logic [31:0] val;
    logic        we;
    logic        sel;
    idle_exp_t   e;
    int          n;
    int          w;
    int          exp_n;
    logic [31:0] exp_rd;
    logic        exp_err;
    bit          done;
    val     = $urandom;
    we      = (be != 4'h0);
    sel     = (region_of(a) == 2);
    exp_n   = 1 + ((k <= int'(TO)) ? k : int'(TO));
    exp_err = (k > int'(TO));
    exp_rd  = (k <= int'(TO) && !we) ? val : 32'h0;
    @(posedge clk) #1;
    drive(a, wd, be, ld, 1'b0);
    e = model_idle(a, be, ld, 1'b0, bus.dm_rdata);
    @(negedge clk);
    checks++;
    if (observed() !== e) begin
      failures++;
      $display("FAIL %s_access got %h want %h", nm, observed(), e);
    end
    n = 1;
    w = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge clk) #1;
      w++;
      bus.tc_ack   = (w == k);
      bus.tc_rdata = (w == k) ? val : $urandom;
      bus.Req      = $urandom_range(0, 1);
      @(negedge clk);
      if (!bus.stall) begin
        done = 1'b1;
      end else begin
        n++;
        checks++;
        if ({bus.tc_req, bus.tc_sel, bus.tc_addr, bus.tc_we} !== {1'b1, sel, a[3:2], we} ||
            (we && bus.tc_wdata !== wd) || bus.bus_err !== 1'b0) begin
          failures++;
          $display("FAIL %s_wait got req=%b sel=%b addr=%0d we=%b wdata=%h err=%b want 1 %b %0d %b %h 0",
                   nm, bus.tc_req, bus.tc_sel, bus.tc_addr, bus.tc_we, bus.tc_wdata, bus.bus_err,
                   sel, a[3:2], we, wd);
        end
        if (n > int'(TO) + 3) begin
          checks++;
          failures++;
          $display("FAIL %s_stall_bound got stall still high after %0d cycles want %0d", nm, n, exp_n);
          done = 1'b1;
        end
      end
    end
    checks++;
    if (n !== exp_n) begin
      failures++;
      $display("FAIL %s_stall_cycles got %0d want %0d", nm, n, exp_n);
    end
    checks++;
    if ({bus.tc_req, bus.bus_err, bus.m_rdata, bus.ig_we, bus.dm_byte_en} !== {1'b0, exp_err, exp_rd, 1'b0, 4'h0}) begin
      failures++;
      $display("FAIL %s_tdone got req=%b err=%b rdata=%h ig=%b be=%h want 0 %b %h 0 0",
               nm, bus.tc_req, bus.bus_err, bus.m_rdata, bus.ig_we, bus.dm_byte_en, exp_err, exp_rd);
    end
    @(posedge clk) #1;
    idle_in();
    @(negedge clk);
    checks++;
    if ({bus.stall, bus.tc_req, bus.bus_err} !== 3'b000) begin
      failures++;
      $display("FAIL %s_after got stall,req,err=%b want 000", nm, {bus.stall, bus.tc_req, bus.bus_err});
    end
  endtask

  task automatic test_reset();
    idle_in();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.tc_req, bus.tc_we, bus.tc_sel, bus.tc_addr, bus.tc_wdata, bus.ig_we, bus.stall,
         bus.bus_err, bus.dm_byte_en} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b we=%b sel=%b addr=%0d wdata=%h ig=%b stall=%b err=%b be=%h want all 0",
               bus.tc_req, bus.tc_we, bus.tc_sel, bus.tc_addr, bus.tc_wdata, bus.ig_we, bus.stall,
               bus.bus_err, bus.dm_byte_en);
    end
    @(posedge clk) #1;
    reset = 1'b0;
  endtask

  task automatic test_dm();
    idle_access("dm_store_word", 32'h0000_0004, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b0);
    idle_access("dm_store_half", 32'h0000_0102, 32'h1234_0000, 4'b1100, 1'b0, 1'b0);
    idle_access("dm_load", 32'h0000_0200, 32'h0, 4'b0000, 1'b1, 1'b0);
    idle_access("dm_last_word", 32'h0000_2FFC, 32'h5A5A_5A5A, 4'b1111, 1'b1, 1'b0);
    idle_access("dm_boundary_above", 32'h0000_3000, 32'h1, 4'b1111, 1'b0, 1'b0);
  endtask

  task automatic test_timer();
    timer_access("tc0_load_k3", 32'h0000_7F04, 32'h0, 4'b0000, 1'b1, 3);
    timer_access("tc1_store_k1", 32'h0000_7F18, 32'h0000_0012, 4'b1111, 1'b0, 1);
    timer_access("tc0_timeout", 32'h0000_7F00, 32'h0, 4'b0000, 1'b1, int'(TO) + 1);
    timer_access("tc1_ack_at_timeout", 32'h0000_7F14, 32'h0, 4'b0000, 1'b1, int'(TO));
    idle_access("tc0_partial_store", 32'h0000_7F08, 32'h77, 4'b0001, 1'b0, 1'b0);
    idle_access("tc0_above_range", 32'h0000_7F0C, 32'h0, 4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_unmapped_and_req();
    idle_access("unmapped_store", 32'h0000_4000, 32'hCAFE_F00D, 4'b1111, 1'b0, 1'b0);
    idle_access("err_one_cycle", 32'h0000_0000, 32'h0, 4'b0000, 1'b0, 1'b0);
    idle_access("dm_store_req", 32'h0000_0010, 32'hCAFE_F00D, 4'b1111, 1'b0, 1'b1);
    idle_access("unmapped_req", 32'h0000_4000, 32'h0, 4'b1111, 1'b0, 1'b1);
    idle_access("timer_req", 32'h0000_7F04, 32'h0, 4'b0000, 1'b1, 1'b1);
  endtask

  task automatic test_ig();
    idle_access("ig_partial", 32'h0000_7F20, 32'h3, 4'b0011, 1'b0, 1'b0);
    idle_access("ig_word", 32'h0000_7F20, 32'h1, 4'b1111, 1'b0, 1'b0);
    idle_access("ig_pulse_end", 32'h0000_7F20, 32'h0, 4'b0000, 1'b0, 1'b0);
    idle_access("ig_load", 32'h0000_7F20, 32'h0, 4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_twait();
    @(posedge clk) #1;
    drive(32'h0000_7F10, 32'h0, 4'b0000, 1'b1, 1'b0);
    @(posedge clk) #1;
    @(posedge clk) #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.tc_req, bus.stall} !== 2'b11) begin
      failures++;
      $display("FAIL mid_twait_req got req,stall=%b want 11", {bus.tc_req, bus.stall});
    end
    @(posedge clk) #1;
    reset = 1'b0;
    idle_in();
    bus.tc_ack   = 1'b1;
    bus.tc_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if ({bus.tc_req, bus.stall, bus.bus_err} !== 3'b000) begin
      failures++;
      $display("FAIL late_ack got req,stall,err=%b want 000", {bus.tc_req, bus.stall, bus.bus_err});
    end
    idle_access("post_reset_dm_load", 32'h0000_0100, 32'h0, 4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    idle_access("b2b_dm", 32'h0000_0020, 32'h1111_2222, 4'b1111, 1'b0, 1'b0);
    timer_access("b2b_tc1", 32'h0000_7F1B, 32'h0000_ABCD, 4'b1111, 1'b1, 2);
    timer_access("b2b_tc0", 32'h0000_7F08, 32'h0, 4'b0000, 1'b1, 1);
    idle_access("b2b_ig", 32'h0000_7F23, 32'h5, 4'b1111, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        ld;
    logic        rq;
    idle_exp_t   e;
    logic [31:0] unm [8];
    unm = '{32'h0000_3000, 32'h0000_7EFF, 32'h0000_7F0C, 32'h0000_7F0F,
            32'h0000_7F1C, 32'h0000_7F24, 32'h0000_4000, 32'h8000_7F04};
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 4))
        0: a = 32'($urandom_range(0, 32'h2FFF));
        1: a = 32'h7F00 + 32'($urandom_range(0, 11));
        2: a = 32'h7F10 + 32'($urandom_range(0, 11));
        3: a = 32'h7F20 + 32'($urandom_range(0, 3));
        default: a = unm[$urandom_range(0, 7)];
      endcase
      case ($urandom_range(0, 2))
        0: be = 4'h0;
        1: be = 4'hF;
        default: be = 4'($urandom);
      endcase
      wd = $urandom;
      ld = 1'($urandom);
      rq = ($urandom_range(0, 3) == 0);
      e  = model_idle(a, be, ld, rq, 32'h0);
      if (e.stall) timer_access("rand_timer", a, wd, be, ld, $urandom_range(1, int'(TO) + 1));
      else         idle_access("rand_idle", a, wd, be, ld, rq);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle_in();
    test_reset();
    test_dm();
    test_timer();
    test_unmapped_and_req();
    test_ig();
    test_reset_mid_twait();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $fatal(1);
  end

endmodule
